// File: rtl/segre_dcache_tl_ctrl_if.sv
// segre_dcache_tl_ctrl_if: EX request, TL->MEM register and MMU refill signals of the dcache TL stage
interface segre_dcache_tl_ctrl_if #(
   parameter int ADDR_W    = 32,
   parameter int NUM_WAYS  = 4,
   parameter int PAYLOAD_W = 96
);
   logic                        ex_rd_i, ex_wr_i, flush_i, mmu_rdy_i;
   logic [ADDR_W-1:0]           ex_addr_i;
   logic [PAYLOAD_W-1:0]        ex_payload_i;
   logic                        tl_valid_o, tl_rd_o, tl_wr_o;
   logic [ADDR_W-1:0]           tl_addr_o, mmu_addr_o, mmu_wb_addr_o;
   logic [$clog2(NUM_WAYS)-1:0] tl_hit_way_o;
   logic [PAYLOAD_W-1:0]        tl_payload_o;
   logic                        mmu_req_o, mmu_wb_o, stall_o, busy_o;
   modport slave (
      input  ex_rd_i, ex_wr_i, ex_addr_i, ex_payload_i, flush_i, mmu_rdy_i,
      output tl_valid_o, tl_rd_o, tl_wr_o, tl_addr_o, tl_hit_way_o, tl_payload_o,
      output mmu_req_o, mmu_addr_o, mmu_wb_o, mmu_wb_addr_o, stall_o, busy_o
   );
   modport master (
      output ex_rd_i, ex_wr_i, ex_addr_i, ex_payload_i, flush_i, mmu_rdy_i,
      input  tl_valid_o, tl_rd_o, tl_wr_o, tl_addr_o, tl_hit_way_o, tl_payload_o,
      input  mmu_req_o, mmu_addr_o, mmu_wb_o, mmu_wb_addr_o, stall_o, busy_o
   );
endinterface

// File: rtl/segre_dcache_tl_ctrl.sv
// segre_dcache_tl_ctrl: dcache tag-lookup stage with tree-PLRU, miss/refill FSM and invalidate-all flush
module segre_dcache_tl_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int NUM_WAYS   = 4,
   parameter int NUM_SETS   = 16,
   parameter int LINE_BYTES = 16,
   parameter int PAYLOAD_W  = 96
)(
   input logic clk_i,
   input logic rst_i,
   segre_dcache_tl_ctrl_if.slave bus
);
   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
   localparam int WAY_W = $clog2(NUM_WAYS);

   typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_t;

   state_t               state_q, state_d;
   logic [TAG_W-1:0]     tag_q [NUM_SETS][NUM_WAYS];
   logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
   logic [NUM_WAYS-1:0]  dirty_q [NUM_SETS];
   logic [NUM_WAYS-1:0]  plru_q  [NUM_SETS];
   logic [IDX_W-1:0]     idx, miss_idx_q, flush_cnt_q, flush_cnt_d;
   logic [TAG_W-1:0]     tag, miss_tag_q, victim_tag_q;
   logic [WAY_W-1:0]     hit_way, victim, victim_q, tl_way_q;
   logic                 req, hit, miss, stall, refill, flush_pend_q, flush_pend_d, wb_q;
   logic                 tl_valid_q, tl_rd_q, tl_wr_q;
   logic [ADDR_W-1:0]    tl_addr_q;
   logic [PAYLOAD_W-1:0] tl_payload_q;

   // Tree nodes are heap-numbered from 1 (root); a node bit of 1 sends the victim walk right.
   function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-1:0] t);
      logic [WAY_W-1:0] n;
      n = WAY_W'(1);
      for (int l = 0; l < WAY_W; l++) n = WAY_W'({n, t[n]});
      return n;
   endfunction

   function automatic logic [NUM_WAYS-1:0] plru_touch(input logic [NUM_WAYS-1:0] t, input logic [WAY_W-1:0] w);
      logic [WAY_W-1:0] n;
      plru_touch = t;
      n = WAY_W'(1);
      for (int l = WAY_W - 1; l >= 0; l--) begin
         plru_touch[n] = ~w[l];
         n = WAY_W'({n, w[l]});
      end
   endfunction

   assign idx    = bus.ex_addr_i[OFF_W +: IDX_W];
   assign tag    = bus.ex_addr_i[ADDR_W-1 -: TAG_W];
   assign req    = bus.ex_rd_i | bus.ex_wr_i;
   assign refill = state_q == REFILL;

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      victim  = plru_victim(plru_q[idx]);
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[idx][w]) victim = WAY_W'(w);
      end
   end

   assign miss = state_q == IDLE && req && !hit;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         flush_cnt_q  <= '0;
         flush_pend_q <= 1'b0;
         miss_tag_q   <= '0;
         miss_idx_q   <= '0;
         victim_q     <= '0;
         victim_tag_q <= '0;
         wb_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_cnt_q  <= flush_cnt_d;
         flush_pend_q <= flush_pend_d;
         if (miss) begin
            miss_tag_q   <= tag;
            miss_idx_q   <= idx;
            victim_q     <= victim;
            victim_tag_q <= tag_q[idx][victim];
            wb_q         <= valid_q[idx][victim] & dirty_q[idx][victim];
         end
      end
   end

   // A flush that arrives with a miss or mid-refill is deferred and entered straight from REFILL.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = miss ? REFILL : bus.flush_i ? FLUSH : IDLE;
         REFILL:  if (bus.mmu_rdy_i) state_d = (flush_pend_q || bus.flush_i) ? FLUSH : IDLE;
         FLUSH:   if (flush_cnt_q == IDX_W'(NUM_SETS - 1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      flush_cnt_d  = (state_q == FLUSH) ? flush_cnt_q + IDX_W'(1) : '0;
      flush_pend_d = (refill && bus.mmu_rdy_i) ? 1'b0 : flush_pend_q | (bus.flush_i & (miss | refill));
   end

   always_comb begin
      stall             = miss || state_q != IDLE;
      bus.stall_o       = stall;
      bus.busy_o        = state_q == FLUSH;
      bus.mmu_req_o     = refill;
      bus.mmu_addr_o    = refill ? {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}} : '0;
      bus.mmu_wb_o      = refill & wb_q;
      bus.mmu_wb_addr_o = refill ? {victim_tag_q, miss_idx_q, {OFF_W{1'b0}}} : '0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else if (state_q == FLUSH) begin
         valid_q[flush_cnt_q] <= '0;
         dirty_q[flush_cnt_q] <= '0;
         plru_q[flush_cnt_q]  <= '0;
      end else if (refill && bus.mmu_rdy_i) begin
         valid_q[miss_idx_q][victim_q] <= 1'b1;
         dirty_q[miss_idx_q][victim_q] <= 1'b0;
      end else if (state_q == IDLE && req && hit) begin
         plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
         if (bus.ex_wr_i) dirty_q[idx][hit_way] <= 1'b1;
      end
   end

   // Tags need no reset: a line is only looked at once its valid bit is set.
   always_ff @(posedge clk_i) begin
      if (refill && bus.mmu_rdy_i) tag_q[miss_idx_q][victim_q] <= miss_tag_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tl_valid_q   <= 1'b0;
         tl_rd_q      <= 1'b0;
         tl_wr_q      <= 1'b0;
         tl_addr_q    <= '0;
         tl_payload_q <= '0;
         tl_way_q     <= '0;
      end else if (stall) begin
         tl_valid_q <= 1'b0;
         tl_rd_q    <= 1'b0;
         tl_wr_q    <= 1'b0;
      end else begin
         tl_valid_q   <= 1'b1;
         tl_rd_q      <= bus.ex_rd_i;
         tl_wr_q      <= bus.ex_wr_i;
         tl_addr_q    <= bus.ex_addr_i;
         tl_payload_q <= bus.ex_payload_i;
         tl_way_q     <= hit_way;
      end
   end

   assign bus.tl_valid_o   = tl_valid_q;
   assign bus.tl_rd_o      = tl_rd_q;
   assign bus.tl_wr_o      = tl_wr_q;
   assign bus.tl_addr_o    = tl_addr_q;
   assign bus.tl_payload_o = tl_payload_q;
   assign bus.tl_hit_way_o = tl_way_q;
endmodule

// File: tb/tb_segre_dcache_tl_ctrl.sv
// tb_segre_dcache_tl_ctrl: directed tables, hand sequences and a random run against a cache model
module tb_segre_dcache_tl_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   segre_dcache_tl_ctrl_if #(.ADDR_W(32), .NUM_WAYS(4), .PAYLOAD_W(96)) b ();
   segre_dcache_tl_ctrl_if #(.ADDR_W(32), .NUM_WAYS(2), .PAYLOAD_W(96)) b2 ();

   segre_dcache_tl_ctrl #(.ADDR_W(32), .NUM_WAYS(4), .NUM_SETS(16), .LINE_BYTES(16), .PAYLOAD_W(96))
      dut (.clk_i(clk), .rst_i(rst), .bus(b));
   segre_dcache_tl_ctrl #(.ADDR_W(32), .NUM_WAYS(2), .NUM_SETS(16), .LINE_BYTES(16), .PAYLOAD_W(96))
      dut2 (.clk_i(clk), .rst_i(rst), .bus(b2));

   // Reference cache: 16 sets x 4 ways, PLRU tree as heap nodes 1..3 (1 = victim on the right half)
   logic [23:0] m_tag  [16][4];
   bit          m_val  [16][4];
   bit          m_dty  [16][4];
   bit          m_node [16][4];

   typedef struct {
      bit          rd, wr;
      logic [31:0] addr;
      int          dly;
      bit          miss;
      int          way;
      bit          wb;
      logic [31:0] wba;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_clear();
      for (int s = 0; s < 16; s++)
         for (int w = 0; w < 4; w++) begin
            m_val[s][w] = 0; m_dty[s][w] = 0; m_node[s][w] = 0;
         end
   endtask

   function automatic int m_find(int s, logic [23:0] t);
      for (int w = 0; w < 4; w++) if (m_val[s][w] && m_tag[s][w] == t) return w;
      return -1;
   endfunction

   function automatic int m_victim(int s);
      int lo, size, node;
      for (int w = 0; w < 4; w++) if (!m_val[s][w]) return w;
      lo = 0; size = 4; node = 1;
      while (size > 1) begin
         size = size / 2;
         if (m_node[s][node]) begin lo += size; node = 2 * node + 1; end
         else node = 2 * node;
      end
      return lo;
   endfunction

   task automatic m_touch(int s, int w);
      int lo, size, node;
      lo = 0; size = 4; node = 1;
      while (size > 1) begin
         size = size / 2;
         if (w >= lo + size) begin m_node[s][node] = 0; lo += size; node = 2 * node + 1; end
         else begin m_node[s][node] = 1; node = 2 * node; end
      end
   endtask

   // One memop (or non-memop) on the 4-way DUT, refill answered dly cycles after the miss.
   task automatic access(input bit rd, input bit wr, input logic [31:0] a, input int dly,
                         output bit o_miss, output int o_way, output bit o_wb, output logic [31:0] o_wba);
      int s, ew, vic, st;
      bit emiss, ewb;
      logic [23:0] t;
      logic [95:0] pl;
      s = int'(a[7:4]);
      t = a[31:8];
      pl = {$urandom, $urandom, $urandom};
      ew = m_find(s, t);
      emiss = (rd || wr) && ew < 0;
      b.ex_rd_i = rd; b.ex_wr_i = wr; b.ex_addr_i = a; b.ex_payload_i = pl;
      #1;
      chk("lookup_stall", b.stall_o, emiss);
      o_miss = b.stall_o; o_wb = 0; o_wba = '0;
      if (emiss) begin
         vic = m_victim(s);
         ewb = m_val[s][vic] && m_dty[s][vic];
         st = 1;
         for (int k = 1; k <= dly; k++) begin
            @(posedge clk); #1;
            st += int'(b.stall_o);
            chk("refill_req", b.mmu_req_o, 1'b1);
            chk("refill_addr", b.mmu_addr_o, {a[31:4], 4'h0});
            chk("refill_wb", b.mmu_wb_o, ewb);
            if (ewb) chk("refill_wb_addr", b.mmu_wb_addr_o, {m_tag[s][vic], a[7:4], 4'h0});
            if (k == 1) begin
               chk("refill_bubble", b.tl_valid_o, 1'b0);
               o_wb = b.mmu_wb_o; o_wba = b.mmu_wb_addr_o;
            end
            if (k == dly) b.mmu_rdy_i = 1'b1;
         end
         @(posedge clk); #1;
         b.mmu_rdy_i = 1'b0;
         chk("miss_penalty", st, dly + 1);
         m_tag[s][vic] = t; m_val[s][vic] = 1; m_dty[s][vic] = 0;
         ew = vic;
      end
      chk("hit_no_stall", b.stall_o, 1'b0);
      chk("idle_no_req", b.mmu_req_o, 1'b0);
      @(posedge clk); #1;
      chk("tl_valid", b.tl_valid_o, 1'b1);
      chk("tl_rd", b.tl_rd_o, rd);
      chk("tl_wr", b.tl_wr_o, wr);
      chk("tl_addr", b.tl_addr_o, a);
      chk("tl_payload", b.tl_payload_o, pl);
      if (rd || wr) begin
         chk("tl_way", b.tl_hit_way_o, ew);
         m_touch(s, ew);
         if (wr) m_dty[s][ew] = 1;
      end
      o_way = int'(b.tl_hit_way_o);
      b.ex_rd_i = 0; b.ex_wr_i = 0;
   endtask

   // Flush pulse in an idle cycle; a second pulse mid-flush must not extend it.
   task automatic do_flush();
      int n;
      b.flush_i = 1'b1;
      #1;
      chk("flush_start_nostall", b.stall_o, 1'b0);
      @(posedge clk); #1;
      b.flush_i = 1'b0;
      n = 0;
      while (b.busy_o && n < 40) begin
         chk("flush_stall", b.stall_o, 1'b1);
         n++;
         b.flush_i = (n == 5);
         @(posedge clk); #1;
      end
      b.flush_i = 1'b0;
      chk("flush_len", n, 16);
      m_clear();
   endtask

   task automatic access2(input bit rd, input bit wr, input logic [31:0] a,
                          output bit miss, output bit wb, output logic [31:0] wba, output logic [31:0] maddr, output int way);
      b2.ex_rd_i = rd; b2.ex_wr_i = wr; b2.ex_addr_i = a;
      #1;
      miss = b2.stall_o; wb = 0; wba = '0; maddr = '0;
      if (miss) begin
         @(posedge clk); #1;
         wb = b2.mmu_wb_o; wba = b2.mmu_wb_addr_o; maddr = b2.mmu_addr_o;
         b2.mmu_rdy_i = 1'b1;
         @(posedge clk); #1;
         b2.mmu_rdy_i = 1'b0;
      end
      @(posedge clk); #1;
      way = int'(b2.tl_hit_way_o);
      b2.ex_rd_i = 0; b2.ex_wr_i = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit om, owb;
      int ow, n;
      logic [31:0] owba, omaddr;
      tbl[0] = '{1, 0, 32'h040, 2, 1, 0, 0, 32'h0};
      tbl[1] = '{1, 0, 32'h140, 1, 1, 1, 0, 32'h0};
      tbl[2] = '{1, 0, 32'h240, 3, 1, 2, 0, 32'h0};
      tbl[3] = '{0, 1, 32'h340, 1, 1, 3, 0, 32'h0};
      tbl[4] = '{1, 0, 32'h044, 1, 0, 0, 0, 32'h0};
      tbl[5] = '{1, 0, 32'h440, 2, 1, 2, 0, 32'h0};
      tbl[6] = '{1, 0, 32'h240, 1, 1, 1, 0, 32'h0};
      tbl[7] = '{1, 0, 32'h540, 2, 1, 3, 1, 32'h340};
      {b.ex_rd_i, b.ex_wr_i, b.flush_i, b.mmu_rdy_i} = '0;
      b.ex_addr_i = '0; b.ex_payload_i = '0;
      {b2.ex_rd_i, b2.ex_wr_i, b2.flush_i, b2.mmu_rdy_i} = '0;
      b2.ex_addr_i = '0; b2.ex_payload_i = '0;
      m_clear();

      repeat (2) @(posedge clk);
      #1;
      chk("rst_tl_valid", b.tl_valid_o, 1'b0);
      chk("rst_mmu_req", b.mmu_req_o, 1'b0);
      chk("rst_stall", b.stall_o, 1'b0);
      chk("rst_busy", b.busy_o, 1'b0);
      chk("rst_tl_addr", b.tl_addr_o, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("nonmem_pass_valid", b.tl_valid_o, 1'b1);

      // cold read, refill answered 3 cycles later
      access(1, 0, 32'h40, 3, om, ow, owb, owba);
      chk("t1_miss", om, 1'b1);
      chk("t1_way", ow, 0);
      chk("t1_wb", owb, 1'b0);

      do_flush();
      access(1, 0, 32'h40, 1, om, ow, owb, owba);
      chk("t4_miss_after_flush", om, 1'b1);
      do_flush();

      for (int i = 0; i < 8; i++) begin
         access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].dly, om, ow, owb, owba);
         chk($sformatf("t2_miss_%0d", i), om, tbl[i].miss);
         chk($sformatf("t2_way_%0d", i), ow, tbl[i].way);
         chk($sformatf("t2_wb_%0d", i), owb, tbl[i].wb);
         if (tbl[i].wb) chk($sformatf("t2_wba_%0d", i), owba, tbl[i].wba);
      end

      // reset two cycles into a refill
      b.ex_rd_i = 1'b1; b.ex_addr_i = 32'h940;
      #1;
      chk("t5_miss", b.stall_o, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("t5_req_before", b.mmu_req_o, 1'b1);
      b.ex_rd_i = 1'b0;
      rst = 1'b1;
      #1;
      chk("t5_req_async", b.mmu_req_o, 1'b0);
      chk("t5_stall_async", b.stall_o, 1'b0);
      @(posedge clk); #1;
      b.mmu_rdy_i = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      b.mmu_rdy_i = 1'b0;
      chk("t5_late_rdy_req", b.mmu_req_o, 1'b0);
      chk("t5_late_rdy_stall", b.stall_o, 1'b0);
      m_clear();

      // flush during refill of 0x40
      b.ex_rd_i = 1'b1; b.ex_addr_i = 32'h40;
      #1;
      chk("t6_miss", b.stall_o, 1'b1);
      @(posedge clk); #1;
      chk("t6_req", b.mmu_req_o, 1'b1);
      b.flush_i = 1'b1;
      @(posedge clk); #1;
      b.flush_i = 1'b0;
      b.mmu_rdy_i = 1'b1;
      @(posedge clk); #1;
      b.mmu_rdy_i = 1'b0;
      chk("t6_flush_bubble", b.tl_valid_o, 1'b0);
      n = 0;
      while (b.busy_o && n < 40) begin
         n++;
         @(posedge clk); #1;
      end
      chk("t6_flush_len", n, 16);
      chk("t6_replay_miss", b.stall_o, 1'b1);
      @(posedge clk); #1;
      chk("t6_req2", b.mmu_req_o, 1'b1);
      chk("t6_addr2", b.mmu_addr_o, 32'h40);
      b.mmu_rdy_i = 1'b1;
      @(posedge clk); #1;
      b.mmu_rdy_i = 1'b0;
      chk("t6_hit_nostall", b.stall_o, 1'b0);
      @(posedge clk); #1;
      chk("t6_tl_rd", b.tl_rd_o, 1'b1);
      chk("t6_tl_way", b.tl_hit_way_o, 2'd0);
      b.ex_rd_i = 1'b0;
      m_clear();
      m_tag[4][0] = 24'h0; m_val[4][0] = 1; m_touch(4, 0);

      for (int i = 0; i < 200; i++) begin
         int r;
         logic [31:0] a;
         r = int'($urandom_range(0, 29));
         a = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
         if (r == 0) do_flush();
         else access(r % 3 == 1, r % 3 == 2, a, int'($urandom_range(1, 4)), om, ow, owb, owba);
      end

      // two-way instance: dirty victim write-back
      access2(0, 1, 32'h080, om, owb, owba, omaddr, ow);
      chk("t3_w080_miss", om, 1'b1);
      chk("t3_w080_way", ow, 0);
      access2(1, 0, 32'h180, om, owb, owba, omaddr, ow);
      chk("t3_r180_way", ow, 1);
      chk("t3_r180_wb", owb, 1'b0);
      access2(1, 0, 32'h280, om, owb, owba, omaddr, ow);
      chk("t3_r280_wb", owb, 1'b1);
      chk("t3_r280_wba", owba, 32'h080);
      chk("t3_r280_addr", omaddr, 32'h280);
      chk("t3_r280_way", ow, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
